demod_channel_arbiter: RTL and testbench
========================================

# demod_channel_arbiter

Round-robin AXI-Stream arbiter that shares the single FM phase-difference demodulator datapath among `N_CH` CORDIC-output channel streams. It sits between the per-channel CORDIC stages and the demodulator and forwards one beat per cycle through a single output register. Each forwarded beat is tagged with its channel index on `m00_axis_tuser`, so downstream logic can keep per-channel angle history and route results. It also supports packet locking, so a channel keeps the datapath until `tlast` or a burst limit is reached.

## Interface
- `C_S00_AXIS_TDATA_WIDTH`, 32, data width of each input lane and of the output
- `N_CH`, 4, number of requesting channels (≥2)
- `MAX_BURST`, 64, maximum beats per locked grant (≥1)
- `CH_W`, `$clog2(N_CH)`, channel tag width (derived)
- `s00_axis_aclk`  in  1  the only clock
- `s00_axis_areset`  in  1  reset, synchronous, active-high
- `ch_enable`  in  N_CH  per-channel request mask
- `lock_mode`  in  1  0 = per-beat interleave; 1 = hold grant until `tlast` or `MAX_BURST`
- `s00_axis_tvalid`  in  N_CH  per-channel valid
- `s00_axis_tdata`  in  N_CH*W  lane k at `[k*W +: W]`
- `s00_axis_tstrb`  in  N_CH*W/8  lane k at `[k*W/8 +: W/8]`
- `s00_axis_tlast`  in  N_CH  per-channel last
- `s00_axis_tready`  out  N_CH  per-channel ready (one-hot or zero)
- `m00_axis_tvalid`, `m00_axis_tdata` (W), `m00_axis_tstrb` (W/8), `m00_axis_tlast`  out  output beat to the demodulator
- `m00_axis_tuser`  out  CH_W  channel index of the current output beat
- `m00_axis_tready`  in  1  downstream ready
- `busy`  out  1  high while in LOCKED
- `active_ch`  out  CH_W  channel holding the lock; also the last-granted channel

## Operation
- req = `s00_axis_tvalid & ch_enable`. The output register is free when `m00_axis_tready || !m00_axis_tvalid`.
- States: ARB and LOCKED.
- ARB: if the output register is free and any req is set, pick g = first set req searching from `last+1` mod N_CH upward with wrap.
  - Assert `s00_axis_tready[g]` combinationally and capture lane g into the output register with `tuser = g`.
  - Go to LOCKED with `burst_cnt = 1` only if `lock_mode`, `!tlast[g]` and `MAX_BURST > 1`. Otherwise stay in ARB with `last = g`.
- LOCKED: only `s00_axis_tready[g]` may assert, gated by the output register being free and by `ch_enable[g]`.
  - On each handshake, increment `burst_cnt`.
  - Return to ARB with `last = g` when the beat has `tlast`, or when `burst_cnt` reaches `MAX_BURST` (this beat counted).
  - If `ch_enable[g]` is low, accept no beat that cycle and go to ARB next cycle with `last = g`.
- `lock_mode` is sampled only at ARB grant decisions. A change during LOCKED has no effect on the current lock.
- A channel whose valid is low inside LOCKED holds the lock; no other channel is served. The burst limit bounds only beats, not idle cycles.
- Output register: when free and not loading, `m00_axis_tvalid` clears after a handshake. When loading, it is overwritten with tvalid = 1, giving full throughput.
- Disabled channels never see tready = 1.

## Timing
- Latency: input handshake on cycle n gives `m00_axis_tvalid` with that beat on cycle n+1.
- Throughput: 1 beat/cycle while `m00_axis_tready = 1`.
- `s00_axis_tready` depends combinationally on `m00_axis_tready`, `s00_axis_tvalid`, `ch_enable`, state and pointer.
- Output data, tstrb, tlast and tuser are stable while `m00_axis_tvalid && !m00_axis_tready`.
- Reset values:
  - `m00_axis_tvalid`, tdata, tstrb, tlast, tuser = 0
  - `busy` = 0, `active_ch` = N_CH-1, state = ARB, `last` = N_CH-1, `burst_cnt` = 0
  - During reset all `s00_axis_tready` = 0.
- Reset mid-packet: the output beat is discarded, and tvalid = 0 the cycle after reset is sampled.
- Counter width is `$clog2(MAX_BURST+1)`.
- The grant pointer wraps from N_CH-1 to 0.

## Structure
- Package `demod_pkg`:
  - `arb_state_t` enum {ARB, LOCKED}
  - default `N_CH`
  - `CH_W` localparam function
- Sub-module `rr_pick`: purely combinational round-robin picker. Inputs are req[N_CH] and last[CH_W]; outputs are any and idx[CH_W]. Reused for any future multi-requester sharing.

## Test plan
- Reset with all 4 lanes valid and enabled → all tready 0 and m00_tvalid 0. After release, the first beats go out tagged tuser 0,1,2,3.
- `lock_mode`=0, all lanes valid, `m00_axis_tready`=1 → tuser sequence 0,1,2,3,0,… at one beat/cycle, tdata matching each lane.
- `lock_mode`=1, ch1 sends a 5-beat packet (tlast on beat 5) while ch2 is valid → five consecutive tuser=1 beats, then tuser=2; busy high for those beats.
- `MAX_BURST`=4, ch0 sends a 10-beat packet without tlast, ch3 valid → 4 ch0 beats, then one ch3 beat, then ch0 regains the lock.
- `m00_axis_tready`=0 for 3 cycles with the output full → all s00 tready 0 and output held stable. On release, no beat is lost or duplicated.
- `ch_enable[2]`=0 with ch2 valid → tready[2] never 1 and tuser never 2. Clearing `ch_enable[1]` mid-lock → no ch1 beat accepted, state returns to ARB next cycle.

Source files
------------

// File: rtl/demod_pkg.sv
// Shared types and helpers for the demodulator channel arbiter.
// Holds the arbiter state encoding and channel-tag width helper.
package demod_pkg;

  typedef enum logic {
    ARB,
    LOCKED
  } arb_state_t;

  localparam int DEF_N_CH = 4;

  function automatic int ch_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/demod_channel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last,
// wrapping from N_CH-1 back to 0.
module rr_pick
  import demod_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [CH_W-1:0] last,
  output logic            any,
  output logic [CH_W-1:0] idx
);

  logic [CH_W-1:0] c;

  always_comb begin
    any = 1'b0;
    idx = '0;
    c   = '0;
    for (int i = 1; i <= N_CH; i++) begin
      c = CH_W'((int'(last) + i) % N_CH);
      if (!any && req[c]) begin
        any = 1'b1;
        idx = c;
      end
    end
  end

endmodule

// File: rtl/demod_channel_arbiter.sv
// Round-robin AXI-Stream arbiter feeding the shared FM demodulator,
// with optional packet locking bounded by a burst limit.
module demod_channel_arbiter
  import demod_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int N_CH      = DEF_N_CH,
  parameter int MAX_BURST = 64,
  parameter int CH_W      = ch_w(N_CH)
) (
  input  logic                                   s00_axis_aclk,
  input  logic                                   s00_axis_areset,
  input  logic [N_CH-1:0]                        ch_enable,
  input  logic                                   lock_mode,
  input  logic [N_CH-1:0]                        s00_axis_tvalid,
  input  logic [N_CH*C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  input  logic [N_CH*C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic [N_CH-1:0]                        s00_axis_tlast,
  output logic [N_CH-1:0]                        s00_axis_tready,
  output logic                                   m00_axis_tvalid,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0]      m00_axis_tdata,
  output logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]    m00_axis_tstrb,
  output logic                                   m00_axis_tlast,
  output logic [CH_W-1:0]                        m00_axis_tuser,
  input  logic                                   m00_axis_tready,
  output logic                                   busy,
  output logic [CH_W-1:0]                        active_ch
);

  localparam int W     = C_S00_AXIS_TDATA_WIDTH;
  localparam int SW    = W / 8;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

  arb_state_t      state, state_n;
  logic [CH_W-1:0] last, last_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [N_CH-1:0] req, grant;
  logic [CH_W-1:0] sel;
  logic            free, load;
  logic            pick_any;
  logic [CH_W-1:0] pick_idx;

  assign req  = s00_axis_tvalid & ch_enable;
  assign free = m00_axis_tready || !m00_axis_tvalid;

  rr_pick #(
    .N_CH (N_CH),
    .CH_W (CH_W)
  ) u_pick (
    .req  (req),
    .last (last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  always_comb begin
    state_n = state;
    last_n  = last;
    cnt_n   = cnt;
    grant   = '0;
    load    = 1'b0;
    sel     = pick_idx;
    if (!s00_axis_areset) begin
      unique case (state)
        ARB: begin
          if (free && pick_any) begin
            grant[pick_idx] = 1'b1;
            load   = 1'b1;
            last_n = pick_idx;
            if (lock_mode && !s00_axis_tlast[pick_idx] && MAX_BURST > 1) begin
              state_n = LOCKED;
              cnt_n   = CNT_W'(1);
            end
          end
        end
        LOCKED: begin
          sel = last;
          if (!ch_enable[last]) begin
            state_n = ARB;
            cnt_n   = '0;
          end else if (free && s00_axis_tvalid[last]) begin
            grant[last] = 1'b1;
            load  = 1'b1;
            cnt_n = cnt + CNT_W'(1);
            if (s00_axis_tlast[last] || cnt_n == MAX_CNT) begin
              state_n = ARB;
              cnt_n   = '0;
            end
          end
        end
        default: state_n = ARB;
      endcase
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      state <= ARB;
      last  <= CH_W'(N_CH - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      m00_axis_tvalid <= 1'b0;
      m00_axis_tdata  <= '0;
      m00_axis_tstrb  <= '0;
      m00_axis_tlast  <= 1'b0;
      m00_axis_tuser  <= '0;
    end else if (load) begin
      m00_axis_tvalid <= 1'b1;
      m00_axis_tdata  <= s00_axis_tdata[sel*W +: W];
      m00_axis_tstrb  <= s00_axis_tstrb[sel*SW +: SW];
      m00_axis_tlast  <= s00_axis_tlast[sel];
      m00_axis_tuser  <= sel;
    end else if (m00_axis_tready) begin
      m00_axis_tvalid <= 1'b0;
    end
  end

  assign s00_axis_tready = grant;
  assign busy      = (state == LOCKED);
  assign active_ch = last;

endmodule

// File: tb/tb_demod_channel_arbiter.sv
// Directed table-driven bench for demod_channel_arbiter, plus a
// burst-limit sequence on a second instance with MAX_BURST = 4.
module tb_demod_channel_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, lk, mr;
  logic [3:0]   en, v, l;
  logic [127:0] sd;
  logic [15:0]  ss;
  logic [3:0]   rdy;
  logic         mv, ml, bz;
  logic [31:0]  md;
  logic [3:0]   ms;
  logic [1:0]   mu, ac;

  logic         b_rst, b_lk, b_mr;
  logic [3:0]   b_en, b_v, b_l;
  logic [3:0]   b_rdy;
  logic         b_mv, b_ml, b_bz;
  logic [31:0]  b_md;
  logic [3:0]   b_ms;
  logic [1:0]   b_mu, b_ac;

  demod_channel_arbiter #(
    .C_S00_AXIS_TDATA_WIDTH (32),
    .N_CH      (4),
    .MAX_BURST (64)
  ) dut (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (rst),
    .ch_enable       (en),
    .lock_mode       (lk),
    .s00_axis_tvalid (v),
    .s00_axis_tdata  (sd),
    .s00_axis_tstrb  (ss),
    .s00_axis_tlast  (l),
    .s00_axis_tready (rdy),
    .m00_axis_tvalid (mv),
    .m00_axis_tdata  (md),
    .m00_axis_tstrb  (ms),
    .m00_axis_tlast  (ml),
    .m00_axis_tuser  (mu),
    .m00_axis_tready (mr),
    .busy            (bz),
    .active_ch       (ac)
  );

  demod_channel_arbiter #(
    .C_S00_AXIS_TDATA_WIDTH (32),
    .N_CH      (4),
    .MAX_BURST (4)
  ) dut4 (
    .s00_axis_aclk   (clk),
    .s00_axis_areset (b_rst),
    .ch_enable       (b_en),
    .lock_mode       (b_lk),
    .s00_axis_tvalid (b_v),
    .s00_axis_tdata  (sd),
    .s00_axis_tstrb  (ss),
    .s00_axis_tlast  (b_l),
    .s00_axis_tready (b_rdy),
    .m00_axis_tvalid (b_mv),
    .m00_axis_tdata  (b_md),
    .m00_axis_tstrb  (b_ms),
    .m00_axis_tlast  (b_ml),
    .m00_axis_tuser  (b_mu),
    .m00_axis_tready (b_mr),
    .busy            (b_bz),
    .active_ch       (b_ac)
  );

  typedef struct {
    logic       rst;
    logic [3:0] en;
    logic       lk;
    logic [3:0] v;
    logic [3:0] l;
    logic       mr;
    logic [3:0] rdy;
    logic       mv;
    logic [1:0] u;
    logic       ml;
    logic       bz;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] lane_d(input int k);
    return 32'hC0DE_0000 | 32'(k * 273);
  endfunction

  function automatic logic [3:0] lane_s(input int k);
    return 4'(1 << k);
  endfunction

  function automatic vec_t mk(
    input logic r, input logic [3:0] e, input logic k,
    input logic [3:0] vv, input logic [3:0] ll, input logic m,
    input logic [3:0] er, input logic emv, input logic [1:0] eu,
    input logic eml, input logic ebz);
    vec_t t;
    t.rst = r;  t.en = e;  t.lk = k;  t.v = vv; t.l = ll; t.mr = m;
    t.rdy = er; t.mv = emv; t.u = eu; t.ml = eml; t.bz = ebz;
    return t;
  endfunction

  task automatic chk(input string nm, input int step,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", nm, step, act, exp);
    end
  endtask

  logic [1:0] bu [7];
  logic       bb [7];

  initial begin
    for (int k = 0; k < 4; k++) begin
      sd[k*32 +: 32] = lane_d(k);
      ss[k*4 +: 4]   = lane_s(k);
    end
    rst = 1'b1; en = 4'hF; lk = 1'b0; v = 4'hF; l = 4'h0; mr = 1'b1;
    b_rst = 1'b1; b_en = 4'hF; b_lk = 1'b0; b_v = 4'h0;
    b_l = 4'h0; b_mr = 1'b1;

    vq.push_back(mk(1, 4'hF, 0, 4'hF, 4'h0, 1, 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(1, 4'hF, 0, 4'hF, 4'h0, 1, 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 4'hF, 4'h0, 1, 4'h1, 1, 0, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 4'hF, 4'h0, 1, 4'h2, 1, 1, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 4'hF, 4'h0, 1, 4'h4, 1, 2, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 4'hF, 4'h0, 1, 4'h8, 1, 3, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 4'hF, 4'h0, 1, 4'h1, 1, 0, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 4'hF, 4'h0, 1, 4'h2, 1, 1, 0, 0));
    for (int i = 0; i < 3; i++)
      vq.push_back(mk(0, 4'hF, 0, 4'hF, 4'h0, 0, 4'h0, 1, 1, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 4'hF, 4'h0, 1, 4'h4, 1, 2, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 4'hF, 4'h0, 1, 4'h8, 1, 3, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 4'hF, 4'h0, 1, 4'h1, 1, 0, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 4'hF, 4'h0, 1, 4'h2, 1, 1, 0, 0));
    vq.push_back(mk(0, 4'hB, 0, 4'hF, 4'h0, 1, 4'h8, 1, 3, 0, 0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0, 4'hF, 1, 4'h6, 4'h0, 1, 4'h2, 1, 1, 0, 1));
    vq.push_back(mk(0, 4'hF, 1, 4'h6, 4'h2, 1, 4'h2, 1, 1, 1, 0));
    vq.push_back(mk(0, 4'hF, 0, 4'h6, 4'h0, 1, 4'h4, 1, 2, 0, 0));
    vq.push_back(mk(0, 4'hF, 1, 4'h2, 4'h0, 1, 4'h2, 1, 1, 0, 1));
    vq.push_back(mk(0, 4'hD, 1, 4'h2, 4'h0, 1, 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'hD, 0, 4'h3, 4'h0, 1, 4'h1, 1, 0, 0, 0));
    vq.push_back(mk(0, 4'hF, 1, 4'h4, 4'h0, 1, 4'h4, 1, 2, 0, 1));
    vq.push_back(mk(0, 4'hF, 0, 4'hB, 4'h0, 1, 4'h0, 0, 0, 0, 1));
    vq.push_back(mk(0, 4'hF, 0, 4'hF, 4'h4, 1, 4'h4, 1, 2, 1, 0));
    vq.push_back(mk(0, 4'hF, 1, 4'h1, 4'h0, 1, 4'h1, 1, 0, 0, 1));
    vq.push_back(mk(1, 4'hF, 1, 4'hF, 4'h0, 0, 4'h0, 0, 0, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 4'hF, 4'h0, 1, 4'h1, 1, 0, 0, 0));
    vq.push_back(mk(0, 4'hF, 0, 4'hF, 4'h0, 0, 4'h0, 1, 0, 0, 0));

    @(posedge clk); #1;
    foreach (vq[i]) begin
      rst = vq[i].rst; en = vq[i].en; lk = vq[i].lk;
      v = vq[i].v; l = vq[i].l; mr = vq[i].mr;
      @(negedge clk);
      chk("s_tready", i, 32'(rdy), 32'(vq[i].rdy));
      @(posedge clk); #1;
      chk("m_tvalid", i, 32'(mv), 32'(vq[i].mv));
      chk("busy", i, 32'(bz), 32'(vq[i].bz));
      if (vq[i].rst)
        chk("active_ch", i, 32'(ac), 32'd3);
      if (vq[i].mv) begin
        chk("m_tuser", i, 32'(mu), 32'(vq[i].u));
        chk("m_tdata", i, md, lane_d(int'(vq[i].u)));
        chk("m_tstrb", i, 32'(ms), 32'(lane_s(int'(vq[i].u))));
        chk("m_tlast", i, 32'(ml), 32'(vq[i].ml));
      end
    end

    bu = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
    bb = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    b_rst = 1'b0; b_lk = 1'b1; b_v = 4'b1001; b_l = 4'b1000;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("burst_tready", 100 + i, 32'(b_rdy), 32'(lane_s(int'(bu[i]))));
      @(posedge clk); #1;
      chk("burst_tvalid", 100 + i, 32'(b_mv), 32'd1);
      chk("burst_tuser", 100 + i, 32'(b_mu), 32'(bu[i]));
      chk("burst_tdata", 100 + i, b_md, lane_d(int'(bu[i])));
      chk("burst_busy", 100 + i, 32'(b_bz), 32'(bb[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
